// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side bus bundle for the single-port memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding caches and RAM.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;

  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;

  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic [1:0]        ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serializes icache fetches and dcache accesses onto one wait-stated RAM port.
// dcache wins ties; a starvation counter forces an icache grant after STARVE_LIMIT D grants.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  mem_arbiter_if.slave      bus,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {StIdle, StDAcc, StIAcc} state_e;

  localparam logic [1:0] RamAccess = 2'd2;
  localparam logic [1:0] RamError  = 2'd3;
  localparam logic [3:0] Limit     = 4'(STARVE_LIMIT);

  state_e            state_q;
  logic [3:0]        starve_q;
  logic [7:0]        err_q;
  logic              ren_q;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] store_q;

  logic d_req;
  logic i_forced;
  logic done;

  assign d_req    = bus.dREN | bus.dWEN;
  assign i_forced = bus.iREN && (starve_q == Limit);
  assign done     = (state_q != StIdle) && (bus.ramstate == RamAccess);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= StIdle;
      starve_q <= '0;
      err_q    <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (d_req && !i_forced) begin
            state_q <= StDAcc;
            addr_q  <= bus.daddr;
            store_q <= bus.dstore;
            // A simultaneous read+write request is treated as a write.
            wen_q   <= bus.dWEN;
            ren_q   <= !bus.dWEN;
            if (bus.iREN) begin
              starve_q <= (starve_q < Limit) ? starve_q + 4'd1 : Limit;
            end else begin
              starve_q <= '0;
            end
          end else if (bus.iREN) begin
            state_q  <= StIAcc;
            addr_q   <= bus.iaddr;
            store_q  <= '0;
            wen_q    <= 1'b0;
            ren_q    <= 1'b1;
            starve_q <= '0;
          end
        end
        default: begin
          // FREE, BUSY and ERROR all hold the strobes; ERROR is simply retried.
          if (bus.ramstate == RamAccess) begin
            state_q <= StIdle;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
          end else if ((bus.ramstate == RamError) && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign bus.ramREN   = ren_q;
  assign bus.ramWEN   = wen_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;

  always_comb begin
    bus.iwait = 1'b1;
    bus.iload = '0;
    bus.dwait = 1'b1;
    bus.dload = '0;
    if (done && (state_q == StIAcc)) begin
      bus.iwait = 1'b0;
      bus.iload = bus.ramload;
    end
    if (done && (state_q == StDAcc)) begin
      bus.dwait = 1'b0;
      bus.dload = wen_q ? '0 : bus.ramload;
    end
  end

  assign err_count = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected grants are queued when requests are raised
// and checked against the RAM-side strobes and cache-side wait/load on each completion.
module tb_mem_arbiter;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic       CLK;
  logic       nRST;
  logic [7:0] err_count;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .STARVE_LIMIT(4)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .bus      (bus),
    .err_count(err_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] store, input logic [31:0] rdata);
    exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = addr; e.store = store; e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Act as the RAM for the next queued access: wait for a strobe, insert wait states,
  // then complete and check the cache-side response.
  task automatic serve(input int n_busy, input int n_err, input int exp_lat, input bit scramble);
    exp_t e;
    int   lat;
    logic seen;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
      return;
    end
    e    = sb.pop_front();
    seen = 1'b0;
    lat  = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge CLK);
      bus.ramstate = FREE;
      #1;
      lat++;
      seen = bus.ramREN | bus.ramWEN;
    end
    chk("strobe_seen", 32'(seen), 32'd1);
    if (!seen) return;
    if (exp_lat > 0) chk("grant_latency", lat, exp_lat);
    chk("ramaddr", bus.ramaddr, e.addr);
    chk("ramWEN", 32'(bus.ramWEN), 32'(e.wr));
    chk("ramREN", 32'(bus.ramREN), 32'(!e.wr));
    if (e.wr) chk("ramstore", bus.ramstore, e.store);
    if (scramble) begin
      bus.daddr  = 32'h0;
      bus.dstore = 32'h0;
      bus.dREN   = 1'b0;
      bus.dWEN   = 1'b0;
    end
    for (int k = 0; k < n_busy; k++) begin
      bus.ramstate = BUSY;
      #1;
      chk("busy_waits", {30'd0, bus.iwait, bus.dwait}, 32'd3);
      @(negedge CLK);
    end
    for (int k = 0; k < n_err; k++) begin
      bus.ramstate = ERROR;
      #1;
      chk("error_waits", {30'd0, bus.iwait, bus.dwait}, 32'd3);
      @(negedge CLK);
    end
    bus.ramstate = ACCESS;
    bus.ramload  = e.rdata;
    #1;
    chk("ramaddr_hold", bus.ramaddr, e.addr);
    if (e.is_d) begin
      chk("dwait_done", 32'(bus.dwait), 32'd0);
      chk("dload", bus.dload, e.wr ? 32'd0 : e.rdata);
      chk("iwait_other", 32'(bus.iwait), 32'd1);
      chk("iload_other", bus.iload, 32'd0);
    end else begin
      chk("iwait_done", 32'(bus.iwait), 32'd0);
      chk("iload", bus.iload, e.rdata);
      chk("dwait_other", 32'(bus.dwait), 32'd1);
      chk("dload_other", bus.dload, 32'd0);
    end
    @(negedge CLK);
    bus.ramstate = FREE;
    bus.ramload  = 32'h0;
    #1;
    chk("idle_gap", {28'd0, bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait}, 32'd3);
  endtask

  initial begin
    nRST         = 1'b0;
    bus.iREN     = 1'b0;
    bus.iaddr    = 32'h0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = 32'h0;
    bus.dstore   = 32'h0;
    bus.ramload  = 32'h0;
    bus.ramstate = FREE;

    // Reset held: requests must not produce any RAM activity.
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      bus.iREN = k[0];
      bus.dREN = ~k[0];
      bus.dWEN = k[1];
      #1;
      chk("rst_strobes", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
      chk("rst_waits", {30'd0, bus.iwait, bus.dwait}, 32'd3);
      chk("rst_err", 32'(err_count), 32'd0);
    end
    @(negedge CLK);
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
    nRST     = 1'b1;
    @(negedge CLK);
    #1;
    chk("idle_no_req", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);

    // Simultaneous requests: dcache first, then icache.
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h80;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h40;
    push(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
    push(1'b0, 1'b0, 32'h80, 32'h0, 32'h12345678);
    serve(2, 0, 1, 1'b0);
    bus.dREN = 1'b0;
    serve(0, 0, 1, 1'b0);
    bus.iREN = 1'b0;

    // Read+write counts as a write; live inputs change and drop mid-access.
    bus.dREN   = 1'b1;
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h3100;
    bus.dstore = 32'h5;
    push(1'b1, 1'b1, 32'h3100, 32'h5, 32'h77);
    serve(1, 0, 1, 1'b1);
    @(negedge CLK);
    #1;
    chk("dropped_no_regrant", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);

    // Starvation guard: 4 D writes then 1 I read, repeated.
    bus.iREN   = 1'b1;
    bus.iaddr  = 32'h100;
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h200;
    bus.dstore = 32'hA5;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) push(1'b1, 1'b1, 32'h200, 32'hA5, 32'h0);
      push(1'b0, 1'b0, 32'h100, 32'h0, 32'h1000 + 32'(r));
    end
    for (int k = 0; k < 10; k++) serve(0, 0, 1, 1'b0);
    bus.iREN = 1'b0;
    bus.dWEN = 1'b0;

    // ERROR retries during an icache grant.
    @(negedge CLK);
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h300;
    push(1'b0, 1'b0, 32'h300, 32'h0, 32'hBEEF0003);
    serve(0, 3, 0, 1'b0);
    bus.iREN = 1'b0;
    chk("err_count_3", 32'(err_count), 32'd3);
    @(negedge CLK);
    bus.iREN = 1'b1;
    push(1'b0, 1'b0, 32'h300, 32'h0, 32'hBEEF0300);
    serve(0, 300, 0, 1'b0);
    bus.iREN = 1'b0;
    chk("err_count_sat", 32'(err_count), 32'd255);

    // Asynchronous reset in the middle of a dcache access.
    @(negedge CLK);
    bus.dREN  = 1'b1;
    bus.daddr = 32'h500;
    @(negedge CLK);
    bus.ramstate = BUSY;
    #1;
    chk("pre_rst_strobe", 32'(bus.ramREN), 32'd1);
    #1;
    nRST = 1'b0;
    #1;
    chk("midrst_strobes", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
    chk("midrst_addr", bus.ramaddr, 32'd0);
    chk("midrst_waits", {30'd0, bus.iwait, bus.dwait}, 32'd3);
    chk("midrst_err", 32'(err_count), 32'd0);
    @(negedge CLK);
    bus.ramstate = FREE;
    nRST         = 1'b1;
    push(1'b1, 1'b0, 32'h500, 32'h0, 32'hCAFE0001);
    serve(1, 0, 1, 1'b0);
    bus.dREN = 1'b0;

    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
